// File: rtl/dmem_responder.sv
// dmem_responder: load/store responder; LATENCY cycles from acceptance to response, held until resp_ready.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned halfword/word accesses as errors instead of aligning them.
module dmem_responder #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 1024,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [DATA_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  busy
);
   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                state, state_nx;
   logic [3:0]            cnt;
   logic                  lat_we;
   logic [2:0]            lat_f3;
   logic [DATA_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0] lat_wdata;

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   logic [IDX_W-1:0]      idx;
   logic [DATA_WIDTH-1:0] rword;
   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;
   logic [DATA_WIDTH-1:0] load_val;
   logic [DATA_WIDTH-1:0] store_word;
   logic [DATA_WIDTH-1:0] store_mask;
   logic                  acc_err;
   logic                  access;

   assign idx    = lat_addr[IDX_W+1:2];
   assign rword  = mem[idx];
   assign access = (state == WAIT) && (cnt == 4'd0);

   always_comb begin
      acc_err = 1'b0;
      // Power-of-two depth: any set bit above the word index is out of range.
      if (|lat_addr[DATA_WIDTH-1:IDX_W+2]) acc_err = 1'b1;
      if (lat_f3[1:0] == 2'b11 || lat_f3 == 3'b110) acc_err = 1'b1;
      if (lat_we && lat_f3[2]) acc_err = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
      if (lat_f3[1:0] == 2'b01 && lat_addr[0]) acc_err = 1'b1;
      if (lat_f3[1:0] == 2'b10 && lat_addr[1:0] != 2'b00) acc_err = 1'b1;
`endif
   end

   always_comb begin
      byte_sel = rword[{lat_addr[1:0], 3'b000} +: 8];
      half_sel = rword[{lat_addr[1], 4'b0000} +: 16];
      load_val = '0;
      case (lat_f3)
         3'b000:  load_val = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
         3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
         3'b001:  load_val = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
         3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, half_sel};
         3'b010:  load_val = rword;
         default: load_val = '0;
      endcase
   end

   always_comb begin
      store_word = '0;
      store_mask = '0;
      case (lat_f3[1:0])
         2'b00: begin
            store_word[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
            store_mask[{lat_addr[1:0], 3'b000} +: 8] = 8'hFF;
         end
         2'b01: begin
            store_word[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
            store_mask[{lat_addr[1], 4'b0000} +: 16] = 16'hFFFF;
         end
         default: begin
            store_word = lat_wdata;
            store_mask = '1;
         end
      endcase
   end

   // The array is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (access && lat_we && !acc_err)
         mem[idx] <= (rword & ~store_mask) | (store_word & store_mask);
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req_valid)     state_nx = WAIT;
         WAIT:    if (cnt == 4'd0)   state_nx = RESP;
         RESP:    if (resp_ready)    state_nx = IDLE;
         default:                    state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= 4'd0;
         lat_we     <= 1'b0;
         lat_f3     <= 3'b000;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               lat_we    <= req_we;
               lat_f3    <= req_funct3;
               lat_addr  <= req_addr;
               lat_wdata <= req_wdata;
               cnt       <= CNT_INIT;
            end
            WAIT: if (cnt != 4'd0) begin
               cnt <= cnt - 4'd1;
            end else begin
               resp_rdata <= (acc_err || lat_we) ? '0 : load_val;
               resp_err   <= acc_err;
            end
            RESP: if (resp_ready) begin
               resp_rdata <= '0;
               resp_err   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign busy       = (state != IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array transaction model, plus directed literal checks.
module tb_dmem_responder;
   localparam int LAT = 4;
   localparam int MW  = 64;
   localparam int unsigned MEM_BYTES = MW * 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        busy;

   int checks = 0;
   int passes = 0;

   dmem_responder #(.DATA_WIDTH(32), .MEM_WORDS(MW), .LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Transaction-level model: byte-addressed memory, phase 0 idle / 1 waiting / 2 responding.
   logic [7:0]  mmem [MEM_BYTES];
   int          m_phase = 0;
   int          m_left = 0;
   logic        m_we;
   logic [2:0]  m_f3;
   logic [31:0] m_addr, m_wdata;
   logic [31:0] exp_rdata = '0;
   logic        exp_err = 1'b0;

   function automatic void m_access();
      int unsigned sz, a;
      bit uns, err;
      logic [31:0] v;
      sz = 4; uns = 0; err = 0;
      case (m_f3)
         3'b000: sz = 1;
         3'b001: sz = 2;
         3'b010: sz = 4;
         3'b100: begin sz = 1; uns = 1; end
         3'b101: begin sz = 2; uns = 1; end
         default: err = 1;
      endcase
      if (m_we && uns) err = 1;
      if (m_addr >= MEM_BYTES) err = 1;
      a = m_addr;
`ifdef DMEM_MISALIGN_TRAP_EN
      if (a % sz != 0) err = 1;
`else
      a = a - (a % sz);
`endif
      exp_err = err;
      exp_rdata = '0;
      if (!err) begin
         if (m_we) begin
            for (int i = 0; i < int'(sz); i++) mmem[a + i] = m_wdata[8*i +: 8];
         end else begin
            v = '0;
            for (int i = 0; i < int'(sz); i++) v[8*i +: 8] = mmem[a + i];
            if (!uns && sz < 4 && v[8*sz-1])
               for (int i = int'(sz); i < 4; i++) v[8*i +: 8] = 8'hFF;
            exp_rdata = v;
         end
      end
   endfunction

   always @(posedge clk) begin
      if (!rst_n) m_phase = 0;
      else case (m_phase)
         0: if (req_valid) begin
            m_we = req_we; m_f3 = req_funct3; m_addr = req_addr; m_wdata = req_wdata;
            m_left = LAT; m_phase = 1;
         end
         1: begin
            m_left--;
            if (m_left == 0) begin m_access(); m_phase = 2; end
         end
         default: if (resp_ready) m_phase = 0;
      endcase
      #1;
      chk("req_ready", {31'b0, req_ready}, {31'b0, m_phase == 0});
      chk("busy", {31'b0, busy}, {31'b0, m_phase != 0});
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, m_phase == 2});
      if (m_phase == 2 || !rst_n) begin
         chk("resp_rdata", resp_rdata, (m_phase == 2) ? exp_rdata : 32'h0);
         chk("resp_err", {31'b0, resp_err}, {31'b0, (m_phase == 2) ? exp_err : 1'b0});
      end
   end

   task automatic noise(input bit with_ready);
      req_valid  = 1'($urandom);
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      if (with_ready) resp_ready = 1'($urandom);
   endtask

   task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int stall, input bit lit,
                      input logic [31:0] lit_rd, input bit lit_err, input bit noisy);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (resp_valid !== 1'b1 && n < 64) begin
         if (noisy) noise(1'b1);
         @(negedge clk);
         n++;
      end
      resp_ready = 1'b0;
      chk("latency", n, LAT);
      if (lit) begin
         chk("lit_rdata", resp_rdata, lit_rd);
         chk("lit_err", {31'b0, resp_err}, {31'b0, lit_err});
      end
      repeat (stall) begin
         if (noisy) noise(1'b0);
         @(negedge clk);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   logic [2:0] f3_tab [13] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2,
                               3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

   initial begin
      logic [31:0] a;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      rst_n = 1'b1;

      for (int w = 0; w < MW; w++) txn(1, 3'b010, 32'(w * 4), 32'h0, 0, 0, 0, 0, 0);

      txn(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 1, 32'h0, 0, 0);
      txn(0, 3'b010, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF, 0, 0);

      txn(1, 3'b010, 32'h20, 32'h80F07F81, 0, 1, 32'h0, 0, 0);
      txn(0, 3'b000, 32'h20, 32'h0, 0, 1, 32'hFFFFFF81, 0, 0);
      txn(0, 3'b100, 32'h20, 32'h0, 0, 1, 32'h00000081, 0, 0);
      txn(0, 3'b001, 32'h22, 32'h0, 0, 1, 32'hFFFF80F0, 0, 0);
      txn(0, 3'b101, 32'h22, 32'h0, 0, 1, 32'h000080F0, 0, 0);

      txn(1, 3'b010, 32'h30, 32'h11223344, 0, 1, 32'h0, 0, 0);
      txn(1, 3'b000, 32'h31, 32'h000000AA, 0, 1, 32'h0, 0, 0);
      txn(1, 3'b001, 32'h32, 32'h0000BEEF, 0, 1, 32'h0, 0, 0);
      txn(0, 3'b010, 32'h30, 32'h0, 5, 1, 32'hBEEFAA44, 0, 0);

      txn(0, 3'b010, MEM_BYTES, 32'h0, 0, 1, 32'h0, 1, 0);
      txn(1, 3'b100, 32'h10, 32'h0, 0, 1, 32'h0, 1, 0);
      txn(0, 3'b010, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF, 0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
      txn(0, 3'b010, 32'h22, 32'h0, 0, 1, 32'h0, 1, 0);
`else
      txn(0, 3'b010, 32'h22, 32'h0, 0, 1, 32'h80F07F81, 0, 0);
`endif

      txn(1, 3'b010, 32'h40, 32'h12345678, 0, 1, 32'h0, 0, 0);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h5;
      @(negedge clk);
      req_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (LAT + 2) @(negedge clk);
      txn(0, 3'b010, 32'h40, 32'h0, 0, 1, 32'h12345678, 0, 0);

      for (int t = 0; t < 300; t++) begin
         case ($urandom_range(0, 9))
            0:       a = MEM_BYTES + $urandom_range(0, 7);
            1:       a = $urandom;
            default: a = $urandom_range(0, MEM_BYTES - 1);
         endcase
         txn(1'($urandom), f3_tab[$urandom_range(0, 12)], a, $urandom,
             $urandom_range(0, 3), 0, 32'h0, 0, 1);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
